audio_frame_streamer: RTL and testbench

- Parametrised successor to the single-word audio output stage.
- Buffers incoming PCM samples in a FIFO and replays them as an interleaved multi-channel stream.
- Output is paced by an internal sample-rate divider and gated by a prime/run state machine.
- Sits between the sample source (VPI fetch or upstream DSP) and the DAC/dump model; underruns are reported.

---
 rtl/audio_frame_streamer.sv | 134 +++++++++++++
 tb/tb_audio_frame_streamer.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_frame_streamer.sv
// Sample FIFO feeding a DIV-paced interleaved multi-channel output stream.
// A prime/run machine holds off output until the FIFO has PRIME samples and falls back after a starved frame.
module audio_frame_streamer #(
    parameter int unsigned W        = 32,
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned DIV      = 16,
    parameter int unsigned PRIME    = 4
) (
    input  logic                                              c,
    input  logic                                              rn,
    input  logic [W-1:0]                                      in_data,
    input  logic                                              in_valid,
    output logic                                              in_ready,
    input  logic                                              mute,
    input  logic                                              hold,
    output logic [W-1:0]                                      x,
    output logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] x_ch,
    output logic                                              x_stb,
    output logic [$clog2(DEPTH):0]                            level,
    output logic                                              running,
    output logic [15:0]                                       underrun_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int unsigned DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned SW = $clog2(CHANNELS + 1);

    typedef enum logic {
        S_PRIME = 1'b0,
        S_RUN   = 1'b1
    } state_t;

    state_t          state;
    logic [W-1:0]    mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [DW-1:0]   div_cnt;
    logic [CW-1:0]   ch_next;
    logic [SW-1:0]   starve;
    logic [W-1:0]    last;
    logic            push;
    logic            pop;
    logic            tick;
    logic            empty;

    assign in_ready = (level < LW'(DEPTH)) && rn;
    assign push     = in_valid && in_ready;
    assign tick     = (state == S_RUN) && (div_cnt == DW'(DIV - 1));
    assign empty    = (level == '0);
    assign pop      = tick && !empty;

    // Sample storage carries no reset; only the pointers define validity.
    always_ff @(posedge c) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge c or negedge rn) begin
        if (!rn) begin
            state        <= S_PRIME;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            level        <= '0;
            div_cnt      <= '0;
            ch_next      <= '0;
            starve       <= '0;
            last         <= '0;
            x            <= '0;
            x_ch         <= '0;
            x_stb        <= 1'b0;
            running      <= 1'b0;
            underrun_cnt <= '0;
        end else begin
            x_stb <= 1'b0;

            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: ;
            endcase

            unique case (state)
                S_PRIME: begin
                    div_cnt <= '0;
                    if (level >= LW'(PRIME)) begin
                        state   <= S_RUN;
                        running <= 1'b1;
                        x_ch    <= '0;
                        ch_next <= '0;
                        starve  <= '0;
                    end
                end
                S_RUN: begin
                    div_cnt <= tick ? '0 : div_cnt + DW'(1);
                    if (tick) begin
                        x_stb   <= 1'b1;
                        x_ch    <= ch_next;
                        ch_next <= (ch_next == CW'(CHANNELS - 1)) ? '0 : ch_next + CW'(1);
                        if (!empty) begin
                            last   <= mem[rd_ptr];
                            x      <= mute ? '0 : mem[rd_ptr];
                            starve <= '0;
                        end else begin
                            x <= mute ? '0 : (hold ? last : '0);
                            if (underrun_cnt != 16'hFFFF) begin
                                underrun_cnt <= underrun_cnt + 16'd1;
                            end
                            // A whole starved frame sends us back to re-prime.
                            if (starve == SW'(CHANNELS - 1)) begin
                                state   <= S_PRIME;
                                running <= 1'b0;
                                div_cnt <= '0;
                                starve  <= '0;
                            end else begin
                                starve <= starve + SW'(1);
                            end
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_audio_frame_streamer.sv
// Bench for audio_frame_streamer: vector table of prime/stream/underrun/mute frames,
// hand sequences for reset and backpressure, and a randomized run against a queue-based model.
module tb_audio_frame_streamer;

    localparam int unsigned W  = 32;
    localparam int unsigned C  = 2;
    localparam int unsigned D  = 8;
    localparam int unsigned DV = 16;
    localparam int unsigned PR = 4;

    logic          c = 1'b0;
    logic          rn;
    logic [W-1:0]  in_data;
    logic          in_valid;
    logic          in_ready;
    logic          mute;
    logic          hold;
    logic [W-1:0]  x;
    logic [0:0]    x_ch;
    logic          x_stb;
    logic [3:0]    level;
    logic          running;
    logic [15:0]   underrun_cnt;

    int tests = 0;
    int fails = 0;

    audio_frame_streamer #(.W(W), .CHANNELS(C), .DEPTH(D), .DIV(DV), .PRIME(PR)) dut (
        .c(c), .rn(rn), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .mute(mute), .hold(hold), .x(x), .x_ch(x_ch), .x_stb(x_stb), .level(level),
        .running(running), .underrun_cnt(underrun_cnt)
    );

    always #5 c = ~c;

    typedef struct packed {
        logic              hold;
        logic [5:0]        mute;
        logic [3:0][W-1:0] d;
        logic [5:0][W-1:0] ex;
    } vec_t;

    vec_t vt[5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge c);
        #1;
    endtask

    task automatic wait_stb(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!x_stb && n < 200);
        if (!x_stb) begin
            tests++;
            fails++;
            $display("FAIL stb_timeout: no strobe within %0d cycles", n);
        end
    endtask

    task automatic do_reset();
        rn = 1'b0; in_valid = 1'b0; in_data = '0; mute = 1'b0; hold = 1'b0;
        step();
        step();
        rn = 1'b1;
        step();
    endtask

    function automatic vec_t mk(input logic h, input logic [5:0] m,
                                input logic [W-1:0] d0, d1, d2, d3,
                                input logic [W-1:0] e0, e1, e2, e3, e4, e5);
        vec_t v;
        v.hold = h; v.mute = m;
        v.d[0] = d0; v.d[1] = d1; v.d[2] = d2; v.d[3] = d3;
        v.ex[0] = e0; v.ex[1] = e1; v.ex[2] = e2; v.ex[3] = e3; v.ex[4] = e4; v.ex[5] = e5;
        return v;
    endfunction

    // Reference model state
    logic [W-1:0] q[$];
    bit           m_run;
    int           m_rt;
    int           m_starve;
    logic [W-1:0] m_last;
    logic [W-1:0] m_x;
    int           m_ch;
    int           m_ucnt;

    initial begin
        int n;
        int ucnt_exp;
        int acc;
        int pct;
        logic was_ready;

        vt[0] = mk(1'b1, 6'b000000, 32'h11, 32'h22, 32'h33, 32'h44,
                   32'h11, 32'h22, 32'h33, 32'h44, 32'h44, 32'h44);
        vt[1] = mk(1'b0, 6'b000000, 32'hA1, 32'hA2, 32'hA3, 32'hA4,
                   32'hA1, 32'hA2, 32'hA3, 32'hA4, 32'h0, 32'h0);
        vt[2] = mk(1'b1, 6'b001100, 32'h3, 32'h4, 32'h5, 32'h6,
                   32'h3, 32'h4, 32'h0, 32'h0, 32'h6, 32'h6);
        vt[3] = mk(1'b1, 6'b110011, 32'h7, 32'h8, 32'h9, 32'h8000_0001,
                   32'h0, 32'h0, 32'h9, 32'h8000_0001, 32'h0, 32'h0);
        vt[4] = mk(1'b1, 6'b000000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 32'h7FFF_FFFF,
                   32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF);

        // Reset state
        rn = 1'b0; in_valid = 1'b0; in_data = '0; mute = 1'b0; hold = 1'b0;
        #1;
        step();
        chk("rst_x", x, 0);
        chk("rst_ch", x_ch, 0);
        chk("rst_stb", x_stb, 0);
        chk("rst_level", level, 0);
        chk("rst_running", running, 0);
        chk("rst_ucnt", underrun_cnt, 0);
        chk("rst_in_ready", in_ready, 0);
        rn = 1'b1;
        step();
        chk("rel_in_ready", in_ready, 1);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (x_stb) n++;
        end
        chk("idle_strobes", n, 0);
        chk("idle_running", running, 0);

        // Vector table: prime with 4 samples, stream, then two starved ticks
        ucnt_exp = 0;
        for (int r = 0; r < 5; r++) begin
            hold = vt[r].hold;
            mute = vt[r].mute[0];
            for (int i = 0; i < 4; i++) begin
                in_valid = 1'b1;
                in_data  = vt[r].d[i];
                step();
            end
            in_valid = 1'b0;
            chk($sformatf("v%0d_level4", r), level, 4);
            chk($sformatf("v%0d_not_yet_running", r), running, 0);
            step();
            chk($sformatf("v%0d_running", r), running, 1);
            for (int s = 0; s < 6; s++) begin
                mute = vt[r].mute[s];
                wait_stb(n);
                chk($sformatf("v%0d_s%0d_gap", r, s), n, DV);
                chk($sformatf("v%0d_s%0d_x", r, s), x, vt[r].ex[s]);
                chk($sformatf("v%0d_s%0d_ch", r, s), x_ch, s % C);
                chk($sformatf("v%0d_s%0d_level", r, s), level, (s < 4) ? 3 - s : 0);
                chk($sformatf("v%0d_s%0d_ucnt", r, s), underrun_cnt, ucnt_exp + ((s < 4) ? 0 : s - 3));
                chk($sformatf("v%0d_s%0d_running", r, s), running, (s == 5) ? 0 : 1);
            end
            ucnt_exp += 2;
        end

        // Backpressure: FIFO fills to DEPTH before the first pop
        do_reset();
        in_valid = 1'b1;
        in_data  = 32'd1;
        acc = 0;
        for (int i = 0; i < 12; i++) begin
            was_ready = in_ready;
            step();
            if (was_ready) begin
                acc++;
                in_data = W'(acc + 1);
            end
        end
        in_valid = 1'b0;
        chk("bp_accepts", acc, D);
        chk("bp_level", level, D);
        chk("bp_in_ready", in_ready, 0);
        for (int s = 0; s < 8; s++) begin
            wait_stb(n);
            chk($sformatf("bp_drain%0d", s), x, s + 1);
        end
        wait_stb(n);
        chk("bp_no_ninth", x, 0);
        chk("bp_ucnt", underrun_cnt, 1);
        wait_stb(n);
        chk("bp_back_to_prime", running, 0);

        // Reset in the middle of RUN, asserted during a tick cycle
        do_reset();
        hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = 32'hC1 + i;
            step();
        end
        in_valid = 1'b0;
        wait_stb(n);
        chk("mr_first", x, 32'hC1);
        chk("mr_level3", level, 3);
        n = 0;
        for (int i = 0; i < DV - 1; i++) begin
            step();
            if (x_stb) n++;
        end
        chk("mr_pre_tick_strobes", n, 0);
        rn = 1'b0;
        #1;
        chk("mr_rst_stb", x_stb, 0);
        chk("mr_rst_level", level, 0);
        chk("mr_rst_running", running, 0);
        chk("mr_rst_in_ready", in_ready, 0);
        chk("mr_rst_x", x, 0);
        n = 0;
        step();
        if (x_stb) n++;
        step();
        if (x_stb) n++;
        rn = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step();
            if (x_stb) n++;
        end
        chk("mr_no_strobe", n, 0);
        chk("mr_level_after", level, 0);
        chk("mr_running_after", running, 0);
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = 32'hD1 + i;
            step();
        end
        in_valid = 1'b0;
        wait_stb(n);
        chk("mr_fresh_x", x, 32'hD1);
        chk("mr_fresh_ch", x_ch, 0);
        wait_stb(n);
        chk("mr_fresh_x2", x, 32'hD2);

        // Randomized run against the reference model
        do_reset();
        q.delete();
        m_run = 0; m_rt = 0; m_starve = 0; m_last = '0; m_x = '0; m_ch = 0; m_ucnt = 0;
        pct = 10;
        for (int cyc = 0; cyc < 6000; cyc++) begin
            int  sz;
            bit  m_tick;
            bit  m_push;
            if (cyc % 600 == 0) pct = int'($urandom_range(3, 30));
            if (cyc % 300 == 0) hold = $urandom_range(0, 1) == 1;
            in_valid = $urandom_range(0, 99) < pct;
            in_data  = $urandom;
            mute     = $urandom_range(0, 7) == 0;

            sz     = q.size();
            m_push = in_valid && (sz < int'(D));
            m_tick = m_run && (m_rt % DV == DV - 1);
            if (m_tick) begin
                m_ch = (m_rt / DV) % C;
                if (sz > 0) begin
                    m_last   = q.pop_front();
                    m_x      = mute ? '0 : m_last;
                    m_starve = 0;
                end else begin
                    m_x = mute ? '0 : (hold ? m_last : '0);
                    if (m_ucnt < 16'hFFFF) m_ucnt++;
                    m_starve++;
                end
            end
            if (m_push) q.push_back(in_data);
            if (!m_run) begin
                if (sz >= int'(PR)) begin
                    m_run = 1; m_rt = 0; m_ch = 0; m_starve = 0;
                end
            end else if (m_tick && sz == 0 && m_starve == int'(C)) begin
                m_run = 0; m_rt = 0; m_starve = 0;
            end else begin
                m_rt++;
            end

            step();
            chk($sformatf("rnd%0d_stb", cyc), x_stb, m_tick);
            chk($sformatf("rnd%0d_level", cyc), level, q.size());
            chk($sformatf("rnd%0d_running", cyc), running, m_run);
            chk($sformatf("rnd%0d_in_ready", cyc), in_ready, q.size() < int'(D));
            chk($sformatf("rnd%0d_x", cyc), x, m_x);
            chk($sformatf("rnd%0d_ch", cyc), x_ch, m_ch);
            if (m_tick) chk($sformatf("rnd%0d_ucnt", cyc), underrun_cnt, m_ucnt);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
        $fatal(1, "watchdog expired");
    end

endmodule
